// File: rtl/lsu_mem_initiator_if.sv
// Request/response and memory-side signal bundle for lsu_mem_initiator.
// master = the initiator itself, slave = the CPU/memory environment around it.
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_len;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_len, req_sign, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_len, req_sign, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Byte/half/word load-store initiator for a word-wide data RAM (RMW for sub-word stores) and MMIO.
// Define MISALIGN_SPLIT_EN to run misaligned RAM accesses as two-word sequences; otherwise they error.
module lsu_mem_initiator #(
    parameter int RD_LAT   = 1,
    parameter int MMIO_BIT = 31
) (
    input  logic                clk,
    input  logic                rst,
    lsu_mem_initiator_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, RESP} state_t;
    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req_ready_q, resp_valid_q, resp_err_q, mem_re_q, mem_we_q;
    logic        req_ready_d, resp_valid_d, resp_err_d, mem_re_d, mem_we_d;
    logic [31:0] resp_rdata_q, mem_addr_q, mem_wdata_q;
    logic [31:0] resp_rdata_d, mem_addr_d, mem_wdata_d;

    logic        we_q, sign_q, mmio_q;
    logic [1:0]  len_q;
    logic [31:0] addr_q, wdata_q, word0_q, load_sh;
    logic [63:0] buf_q, buf_d, buf_new, merged;
    logic        accept, a_mmio, a_err, a_need_rd;

    function automatic logic [31:0] extend_load(input logic [31:0] v, input logic [1:0] len,
                                                input logic sgn);
        logic [31:0] r;
        case (len)
            2'd0:    r = {{24{sgn & v[7]}}, v[7:0]};
            2'd1:    r = {{16{sgn & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Overwrite bytes off..off+n-1 of the little-endian word pair with the right-aligned store data.
    function automatic logic [63:0] merge_store(input logic [63:0] old, input logic [31:0] wd,
                                                input logic [1:0] len, input logic [1:0] off);
        logic [63:0] m;
        logic [63:0] d;
        m = {32'h0, extend_load(32'hFFFF_FFFF, len, 1'b0)} << {off, 3'b000};
        d = {32'h0, wd} << {off, 3'b000};
        return (old & ~m) | (d & m);
    endfunction

    assign accept  = (state_q == IDLE) && bus.req_valid;
    assign a_mmio  = bus.req_addr[MMIO_BIT];
    assign word0_q = {addr_q[31:2], 2'b00};
    assign a_need_rd = !bus.req_we ||
                       (!a_mmio && !(bus.req_len == 2'd2 && bus.req_addr[1:0] == 2'd0));

`ifdef MISALIGN_SPLIT_EN
    logic [2:0]  a_nbytes;
    logic        a_split, split_q, widx_q, widx_d;
    logic [32:0] a_word1;
    logic [31:0] word1_q;

    always_comb begin
        case (bus.req_len)
            2'd0:    a_nbytes = 3'd1;
            2'd1:    a_nbytes = 3'd2;
            default: a_nbytes = 3'd4;
        endcase
    end

    // Bit 32 of a_word1 is the wrap past the top of the address space, which is also rejected.
    assign a_split = ({1'b0, bus.req_addr[1:0]} + a_nbytes) > 3'd4;
    assign a_word1 = {1'b0, bus.req_addr[31:2], 2'b00} + 33'd4;
    assign a_err   = (bus.req_len == 2'd3) ||
                     (!a_mmio && a_split && (a_word1[32] || a_word1[MMIO_BIT]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) widx_q <= 1'b0;
        else     widx_q <= widx_d;
    end
`else
    logic [1:0] a_nbm1;

    assign a_nbm1 = (bus.req_len == 2'd0) ? 2'd0 : (bus.req_len == 2'd1) ? 2'd1 : 2'd3;
    assign a_err  = (bus.req_len == 2'd3) ||
                    (!a_mmio && ((bus.req_addr[1:0] & a_nbm1) != 2'd0));
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
`ifdef MISALIGN_SPLIT_EN
        widx_d  = widx_q;
        buf_new = widx_q ? {bus.mem_rdata, buf_q[31:0]} : {buf_q[63:32], bus.mem_rdata};
`else
        buf_new = {buf_q[63:32], bus.mem_rdata};
`endif
        merged  = merge_store(buf_new, wdata_q, len_q, addr_q[1:0]);
        load_sh = 32'(buf_new >> {addr_q[1:0], 3'b000});

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    buf_d = 64'h0;
`ifdef MISALIGN_SPLIT_EN
                    widx_d = 1'b0;
`endif
                    if (a_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (a_need_rd) begin
                        state_d    = RD_REQ;
                        mem_re_d   = 1'b1;
                        mem_addr_d = a_mmio ? bus.req_addr : {bus.req_addr[31:2], 2'b00};
                    end else begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = a_mmio ? bus.req_addr : {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = extend_load(bus.req_wdata, bus.req_len, 1'b0);
                    end
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
                cnt_d   = 3'd0;
            end
            RD_WAIT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    buf_d = buf_new;
`ifdef MISALIGN_SPLIT_EN
                    if (split_q && !widx_q) begin
                        widx_d     = 1'b1;
                        state_d    = RD_REQ;
                        mem_re_d   = 1'b1;
                        mem_addr_d = word1_q;
                    end else
`endif
                    if (we_q) begin
                        buf_d = merged;
`ifdef MISALIGN_SPLIT_EN
                        widx_d = 1'b0;
`endif
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word0_q;
                        mem_wdata_d = merged[31:0];
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = extend_load(mmio_q ? bus.mem_rdata : load_sh, len_q, sign_q);
                    end
                end
            end
            WR: begin
`ifdef MISALIGN_SPLIT_EN
                if (split_q && !widx_q) begin
                    widx_d      = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word1_q;
                    mem_wdata_d = buf_q[63:32];
                end else
`endif
                begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // Control and registered outputs: cleared asynchronously so a reset aborts any access at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            len_q   <= bus.req_len;
            sign_q  <= bus.req_sign;
            mmio_q  <= a_mmio;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`ifdef MISALIGN_SPLIT_EN
            split_q <= a_split && !a_mmio;
            word1_q <= a_word1[31:0];
`endif
        end
        buf_q <= buf_d;
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a one-cycle-latency RAM/MMIO model.
module tb_lsu_mem_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_initiator_if bus();
    lsu_mem_initiator #(.RD_LAT(1), .MMIO_BIT(31)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] ram [0:255];
    logic [31:0] rd_r = 32'h0;
    logic [31:0] mmio_rd;
    logic        do_preload;
    assign bus.mem_rdata = rd_r;

    always @(posedge clk) begin
        if (do_preload) begin
            ram[8'h40] <= 32'h8899AABB;
            ram[8'h41] <= 32'h11223344;
        end else if (bus.mem_we && !bus.mem_addr[31]) begin
            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        if (bus.mem_re) rd_r <= bus.mem_addr[31] ? mmio_rd : ram[bus.mem_addr[9:2]];
    end

    int total = 0;
    int bad = 0;
    int nre, nwe, resp_cyc;
    int re_cyc[4];
    int we_cyc[4];
    logic [31:0] re_addr[4];
    logic [31:0] we_addr[4];
    logic [31:0] we_data[4];
    logic [31:0] r_rdata;
    logic r_err, busy_ready, ready_after;

    task automatic preload();
        @(negedge clk) do_preload = 1'b1;
        @(negedge clk) do_preload = 1'b0;
    endtask

    // Issue one request; cycle 0 is the accept edge, observations are taken mid-cycle.
    task automatic do_req(input logic we, input logic [1:0] len, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
        nre = 0; nwe = 0; resp_cyc = -1; r_rdata = 32'hx; r_err = 1'bx;
        busy_ready = 1'b0; ready_after = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_len = len; bus.req_sign = sgn;
        bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.mem_re) begin
                if (nre < 4) begin re_addr[nre] = bus.mem_addr; re_cyc[nre] = k; end
                nre++;
            end
            if (bus.mem_we) begin
                if (nwe < 4) begin we_addr[nwe] = bus.mem_addr; we_data[nwe] = bus.mem_wdata; we_cyc[nwe] = k; end
                nwe++;
            end
            if (bus.resp_valid) begin
                resp_cyc = k; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
                break;
            end
            if (bus.req_ready) busy_ready = 1'b1;
        end
        @(negedge clk);
        ready_after = bus.req_ready;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
        total++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_strobes: got re=%b we=%b want 0 0", bus.mem_re, bus.mem_we); end
        total++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_bus: got addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_load_word();
        preload();
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        total++; if (nre !== 1 || re_addr[0] !== 32'h100 || re_cyc[0] !== 1) begin bad++; $display("FAIL lw_read: got n=%0d addr=%h cyc=%0d want 1 100 1", nre, re_addr[0], re_cyc[0]); end
        total++; if (resp_cyc !== 3) begin bad++; $display("FAIL lw_resp_cycle: got %0d want 3", resp_cyc); end
        total++; if (r_rdata !== 32'h8899AABB || r_err !== 1'b0) begin bad++; $display("FAIL lw_data: got %h err=%b want 8899aabb 0", r_rdata, r_err); end
        total++; if (nwe !== 0) begin bad++; $display("FAIL lw_no_write: got %0d want 0", nwe); end
    endtask

    task automatic test_load_sub();
        preload();
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        total++; if (r_rdata !== 32'hFFFFFF88 || resp_cyc !== 3) begin bad++; $display("FAIL lb_signed: got %h cyc=%0d want ffffff88 3", r_rdata, resp_cyc); end
        do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        total++; if (r_rdata !== 32'h00000088) begin bad++; $display("FAIL lb_unsigned: got %h want 00000088", r_rdata); end
        do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
        total++; if (r_rdata !== 32'hFFFFAABB) begin bad++; $display("FAIL lh_signed: got %h want ffffaabb", r_rdata); end
        do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        total++; if (r_rdata !== 32'h00008899 || re_addr[0] !== 32'h100) begin bad++; $display("FAIL lh_upper: got %h addr=%h want 00008899 100", r_rdata, re_addr[0]); end
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        total++; if (r_rdata !== 32'hFFFFFFAA) begin bad++; $display("FAIL lb_byte1: got %h want ffffffaa", r_rdata); end
    endtask

    task automatic test_store_rmw();
        preload();
        do_req(1'b1, 2'd0, 1'b0, 32'h102, 32'h00000077);
        total++; if (nre !== 1 || re_addr[0] !== 32'h100 || re_cyc[0] !== 1) begin bad++; $display("FAIL sb_read: got n=%0d addr=%h cyc=%0d want 1 100 1", nre, re_addr[0], re_cyc[0]); end
        total++; if (nwe !== 1 || we_addr[0] !== 32'h100 || we_data[0] !== 32'h8877AABB || we_cyc[0] !== 3) begin bad++; $display("FAIL sb_write: got n=%0d addr=%h data=%h cyc=%0d want 1 100 8877aabb 3", nwe, we_addr[0], we_data[0], we_cyc[0]); end
        total++; if (resp_cyc !== 4 || r_rdata !== 32'h0 || r_err !== 1'b0) begin bad++; $display("FAIL sb_resp: got cyc=%0d data=%h err=%b want 4 0 0", resp_cyc, r_rdata, r_err); end
        total++; if (busy_ready !== 1'b0 || ready_after !== 1'b1) begin bad++; $display("FAIL sb_ready: got busy=%b after=%b want 0 1", busy_ready, ready_after); end
        preload();
        do_req(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000CAFE);
`ifdef MISALIGN_SPLIT_EN
        total++; if (nre !== 1 || re_addr[0] !== 32'h100) begin bad++; $display("FAIL sh_read: got n=%0d addr=%h want 1 100", nre, re_addr[0]); end
        total++; if (nwe !== 1 || we_data[0] !== 32'h88CAFEBB || we_addr[0] !== 32'h100) begin bad++; $display("FAIL sh_write: got n=%0d addr=%h data=%h want 1 100 88cafebb", nwe, we_addr[0], we_data[0]); end
        total++; if (busy_ready !== 1'b0 || ready_after !== 1'b1) begin bad++; $display("FAIL sh_ready: got busy=%b after=%b want 0 1", busy_ready, ready_after); end
        preload();
        do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'hDEADBEEF);
        total++; if (nre !== 2 || re_addr[1] !== 32'h104 || re_cyc[1] !== 3) begin bad++; $display("FAIL sw_split_read: got n=%0d addr=%h cyc=%0d want 2 104 3", nre, re_addr[1], re_cyc[1]); end
        total++; if (nwe !== 2 || we_data[0] !== 32'hBEEFAABB || we_data[1] !== 32'h1122DEAD || we_addr[1] !== 32'h104) begin bad++; $display("FAIL sw_split_write: got n=%0d d0=%h d1=%h a1=%h want 2 beefaabb 1122dead 104", nwe, we_data[0], we_data[1], we_addr[1]); end
        total++; if (we_cyc[0] !== 5 || we_cyc[1] !== 6 || resp_cyc !== 7) begin bad++; $display("FAIL sw_split_timing: got we=%0d,%0d resp=%0d want 5,6 7", we_cyc[0], we_cyc[1], resp_cyc); end
`else
        total++; if (r_err !== 1'b1 || resp_cyc !== 1 || nre !== 0 || nwe !== 0) begin bad++; $display("FAIL sh_misalign_err: got err=%b cyc=%0d re=%0d we=%0d want 1 1 0 0", r_err, resp_cyc, nre, nwe); end
`endif
    endtask

    task automatic test_store_aligned();
        preload();
        do_req(1'b1, 2'd2, 1'b0, 32'h104, 32'hA5A55A5A);
        total++; if (nre !== 0 || nwe !== 1 || we_cyc[0] !== 1) begin bad++; $display("FAIL sw_strobes: got re=%0d we=%0d cyc=%0d want 0 1 1", nre, nwe, we_cyc[0]); end
        total++; if (we_addr[0] !== 32'h104 || we_data[0] !== 32'hA5A55A5A || resp_cyc !== 2) begin bad++; $display("FAIL sw_write: got addr=%h data=%h resp=%0d want 104 a5a55a5a 2", we_addr[0], we_data[0], resp_cyc); end
        do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        total++; if (r_rdata !== 32'hA5A55A5A) begin bad++; $display("FAIL sw_readback: got %h want a5a55a5a", r_rdata); end
    endtask

    task automatic test_misaligned();
        preload();
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        total++; if (nre !== 2 || re_addr[0] !== 32'h100 || re_addr[1] !== 32'h104) begin bad++; $display("FAIL lw_split_reads: got n=%0d a0=%h a1=%h want 2 100 104", nre, re_addr[0], re_addr[1]); end
        total++; if (r_rdata !== 32'h33448899 || r_err !== 1'b0 || resp_cyc !== 5) begin bad++; $display("FAIL lw_split_data: got %h err=%b cyc=%0d want 33448899 0 5", r_rdata, r_err, resp_cyc); end
`else
        total++; if (r_err !== 1'b1 || resp_cyc !== 1 || nre !== 0) begin bad++; $display("FAIL lw_misalign_err: got err=%b cyc=%0d re=%0d want 1 1 0", r_err, resp_cyc, nre); end
        total++; if (r_rdata !== 32'h0) begin bad++; $display("FAIL lw_misalign_data: got %h want 0", r_rdata); end
`endif
        do_req(1'b0, 2'd2, 1'b0, 32'h7FFFFFFE, 32'h0);
        total++; if (r_err !== 1'b1 || resp_cyc !== 1 || nre !== 0) begin bad++; $display("FAIL split_into_mmio: got err=%b cyc=%0d re=%0d want 1 1 0", r_err, resp_cyc, nre); end
    endtask

    task automatic test_mmio();
        do_req(1'b1, 2'd2, 1'b0, 32'h80000000, 32'h00001234);
        total++; if (nwe !== 1 || nre !== 0 || we_addr[0] !== 32'h80000000 || we_data[0] !== 32'h00001234) begin bad++; $display("FAIL mmio_sw: got we=%0d re=%0d addr=%h data=%h want 1 0 80000000 00001234", nwe, nre, we_addr[0], we_data[0]); end
        total++; if (resp_cyc !== 2) begin bad++; $display("FAIL mmio_sw_resp: got %0d want 2", resp_cyc); end
        do_req(1'b1, 2'd0, 1'b0, 32'h80000003, 32'hFFFFFF12);
        total++; if (nre !== 0 || we_addr[0] !== 32'h80000003 || we_data[0] !== 32'h00000012) begin bad++; $display("FAIL mmio_sb: got re=%0d addr=%h data=%h want 0 80000003 00000012", nre, we_addr[0], we_data[0]); end
        mmio_rd = 32'h0000F00F;
        do_req(1'b0, 2'd1, 1'b1, 32'h80000004, 32'h0);
        total++; if (nre !== 1 || re_addr[0] !== 32'h80000004 || r_rdata !== 32'hFFFFF00F) begin bad++; $display("FAIL mmio_lh: got re=%0d addr=%h data=%h want 1 80000004 fffff00f", nre, re_addr[0], r_rdata); end
        mmio_rd = 32'h12345680;
        do_req(1'b0, 2'd0, 1'b0, 32'h80000010, 32'h0);
        total++; if (r_rdata !== 32'h00000080 || resp_cyc !== 3) begin bad++; $display("FAIL mmio_lbu: got %h cyc=%0d want 00000080 3", r_rdata, resp_cyc); end
    endtask

    task automatic test_illegal_len();
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        total++; if (r_err !== 1'b1 || resp_cyc !== 1 || nre !== 0 || nwe !== 0) begin bad++; $display("FAIL len3_load: got err=%b cyc=%0d re=%0d we=%0d want 1 1 0 0", r_err, resp_cyc, nre, nwe); end
        do_req(1'b1, 2'd3, 1'b0, 32'h80000000, 32'h5);
        total++; if (r_err !== 1'b1 || resp_cyc !== 1 || nwe !== 0 || r_rdata !== 32'h0) begin bad++; $display("FAIL len3_store: got err=%b cyc=%0d we=%0d data=%h want 1 1 0 0", r_err, resp_cyc, nwe, r_rdata); end
    endtask

    task automatic test_reset_mid();
        preload();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_len = 2'd2; bus.req_sign = 1'b0;
        bus.req_addr = 32'h100; bus.req_wdata = 32'h0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_strobes: got re=%b we=%b rv=%b want 0 0 0", bus.mem_re, bus.mem_we, bus.resp_valid); end
        total++; if (bus.mem_addr !== 32'h0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin bad++; $display("FAIL midrst_data: got addr=%h rdata=%h err=%b want 0 0 0", bus.mem_addr, bus.resp_rdata, bus.resp_err); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_release: got ready=%b rv=%b want 1 0", bus.req_ready, bus.resp_valid); end
        do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        total++; if (r_rdata !== 32'h11223344 || resp_cyc !== 3) begin bad++; $display("FAIL midrst_next_lw: got %h cyc=%0d want 11223344 3", r_rdata, resp_cyc); end
    endtask

    task automatic test_back_to_back();
        int nr;
        int nresp;
        int rc[4];
        nr = 0; nresp = 0; rc[0] = -1; rc[1] = -1;
        preload();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_len = 2'd2; bus.req_sign = 1'b0;
        bus.req_addr = 32'h100; bus.req_wdata = 32'h0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.mem_re) begin
                if (nr < 4) rc[nr] = k;
                nr++;
            end
            if (bus.resp_valid) nresp++;
            if (k == 5) bus.req_valid = 1'b0;
        end
        total++; if (nr !== 2 || rc[0] !== 1 || rc[1] !== 5) begin bad++; $display("FAIL b2b_reads: got n=%0d cyc=%0d,%0d want 2 1,5", nr, rc[0], rc[1]); end
        total++; if (nresp !== 2) begin bad++; $display("FAIL b2b_resps: got %0d want 2", nresp); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_len = 2'd0; bus.req_sign = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        mmio_rd = 32'h0; do_preload = 1'b0;
        test_reset();
        test_load_word();
        test_load_sub();
        test_store_rmw();
        test_store_aligned();
        test_misaligned();
        test_mmio();
        test_illegal_len();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
